// File: rtl/acondicionador_de_entradas.sv
`default_nettype none
// ============================================================================
//  Module   : acondicionador_de_entradas
//  Purpose  : Input conditioning for the Mealy controller's I and S inputs.
//             Each raw asynchronous input passes through a two-flop
//             synchronizer and then a counter-based debouncer. The stage
//             drives stable registered levels and a single-cycle strobe on
//             every accepted 0->1 transition.
//  Ports    : clk      - system clock, all state updates on rising edge
//             reset    - asynchronous, active-high reset
//             I_raw    - raw asynchronous I input
//             S_raw    - raw asynchronous S input
//             I, S     - debounced, synchronized levels (registered)
//             I_pulse  - one-cycle strobe on accepted 0->1 of I
//             S_pulse  - one-cycle strobe on accepted 0->1 of S
//  Params   : DEBOUNCE_CYCLES - cycles a new synchronized level must hold
//             before it is accepted (1..255)
//  Revision : 1.0 - initial release
// ============================================================================
module acondicionador_de_entradas #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic I_raw,
    input  logic S_raw,
    output logic I,
    output logic S,
    output logic I_pulse,
    output logic S_pulse
);

    // Terminal count: the level is accepted on the edge where the counter
    // already holds DEBOUNCE_CYCLES-1 consecutive pending cycles.
    localparam logic [7:0] c_CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    // Channel state is a pure decode of sync2 versus the stable level.
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    // Bit 0 carries the I channel, bit 1 the S channel.
    logic [1:0] w_raw;
    logic [1:0] w_stab;
    logic [1:0] w_pulse;

    assign w_raw = {S_raw, I_raw};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            logic       sync1_q;
            logic       sync2_q;
            logic       stab_q;
            logic       stab_d;
            logic       pulse_q;
            logic       pulse_d;
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;
            logic       w_state;

            // State register: synchronizer, counter, stable level, strobe.
            // Metastability is confined to sync1_q; nothing else reads it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    cnt_q   <= 8'd0;
                    stab_q  <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    sync1_q <= w_raw[g];
                    sync2_q <= sync1_q;
                    cnt_q   <= cnt_d;
                    stab_q  <= stab_d;
                    pulse_q <= pulse_d;
                end
            end

            // A disagreement between the synchronized input and the stable
            // level means a candidate transition is being timed.
            always_comb begin
                w_state = (sync2_q != stab_q) ? ST_PENDING : ST_IDLE;
            end

            // Next-state logic. Dropping back to IDLE before the terminal
            // count clears the counter, so a bounce restarts timing from 0.
            always_comb begin
                cnt_d  = 8'd0;
                stab_d = stab_q;
                case (w_state)
                    ST_PENDING: begin
                        if (cnt_q == c_CNT_LAST) begin
                            stab_d = sync2_q;
                            cnt_d  = 8'd0;
                        end else begin
                            cnt_d  = cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        cnt_d  = 8'd0;
                        stab_d = stab_q;
                    end
                endcase
            end

            // Output logic: strobe only when the stable level is about to
            // go 0->1, so the pulse coincides with the first high cycle.
            always_comb begin
                pulse_d = stab_d & ~stab_q;
            end

            assign w_stab[g]  = stab_q;
            assign w_pulse[g] = pulse_q;
        end
    endgenerate

    assign I       = w_stab[0];
    assign S       = w_stab[1];
    assign I_pulse = w_pulse[0];
    assign S_pulse = w_pulse[1];

endmodule
`default_nettype wire

// File: tb/tb_acondicionador_de_entradas.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acondicionador_de_entradas
//  Purpose  : Self-checking bench for acondicionador_de_entradas. Two
//             instances (N=4 and N=1) share the same stimulus. A reference
//             model built on run lengths of the synchronized input feeds a
//             per-cycle expectation queue that a monitor drains on the
//             falling edge. Directed latency and async-reset checks are
//             added on top.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acondicionador_de_entradas;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic I_raw = 1'b0;
    logic S_raw = 1'b0;

    logic I4, S4, Ip4, Sp4;
    logic I1, S1, Ip1, Sp1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acondicionador_de_entradas #(.DEBOUNCE_CYCLES(4)) u_dut4 (
        .clk     (clk),
        .reset   (reset),
        .I_raw   (I_raw),
        .S_raw   (S_raw),
        .I       (I4),
        .S       (S4),
        .I_pulse (Ip4),
        .S_pulse (Sp4)
    );

    acondicionador_de_entradas #(.DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .I_raw   (I_raw),
        .S_raw   (S_raw),
        .I       (I1),
        .S       (S1),
        .I_pulse (Ip1),
        .S_pulse (Sp1)
    );

    // ------------------------------------------------------------------
    // Reference model. Index [m][c]: m=0 is the N=4 build, m=1 the N=1
    // build; c=0 is I, c=1 is S. A level is accepted once the synchronized
    // input has shown a value different from the stable level on N
    // consecutive sampling edges.
    // ------------------------------------------------------------------
    int   n_deb [2] = '{4, 1};
    logic m_s1    [2][2];
    logic m_s2    [2][2];
    logic m_last  [2][2];
    logic m_stab  [2][2];
    logic m_pulse [2][2];
    int   m_run   [2][2];

    logic [3:0] q4[$];
    logic [3:0] q1[$];

    initial begin
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[m][c] = 1'b0; m_s2[m][c] = 1'b0; m_last[m][c] = 1'b0;
                m_stab[m][c] = 1'b0; m_pulse[m][c] = 1'b0; m_run[m][c] = 0;
            end
        end
    end

    always @(posedge clk) begin
        logic [1:0] raw;
        raw = {S_raw, I_raw};
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 2; c++) begin
                if (reset) begin
                    m_s1[m][c] = 1'b0; m_s2[m][c] = 1'b0; m_last[m][c] = 1'b0;
                    m_stab[m][c] = 1'b0; m_pulse[m][c] = 1'b0; m_run[m][c] = 0;
                end else begin
                    if (m_s2[m][c] == m_last[m][c]) m_run[m][c] = m_run[m][c] + 1;
                    else                            m_run[m][c] = 1;
                    m_last[m][c]  = m_s2[m][c];
                    m_pulse[m][c] = 1'b0;
                    if (m_s2[m][c] != m_stab[m][c] && m_run[m][c] >= n_deb[m]) begin
                        m_stab[m][c]  = m_s2[m][c];
                        m_pulse[m][c] = m_s2[m][c];
                    end
                    m_s2[m][c] = m_s1[m][c];
                    m_s1[m][c] = raw[c];
                end
            end
        end
        q4.push_back({m_stab[0][0], m_stab[0][1], m_pulse[0][0], m_pulse[0][1]});
        q1.push_back({m_stab[1][0], m_stab[1][1], m_pulse[1][0], m_pulse[1][1]});
    end

    // ------------------------------------------------------------------
    // Monitor: one comparison per build per falling edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [3:0] e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            checks++;
            if ({I4, S4, Ip4, Sp4} !== e) begin
                failures++;
                $display("FAIL sb_N4 t=%0t got {I,S,Ip,Sp}=%b expected=%b", $time, {I4, S4, Ip4, Sp4}, e);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if ({I1, S1, Ip1, Sp1} !== e) begin
                failures++;
                $display("FAIL sb_N1 t=%0t got {I,S,Ip,Sp}=%b expected=%b", $time, {I1, S1, Ip1, Sp1}, e);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after the falling edge.
    // ------------------------------------------------------------------
    task automatic step(input logic i, input logic s);
        @(negedge clk);
        #1;
        I_raw = i;
        S_raw = s;
    endtask

    task automatic hold(input int n);
        repeat (n) step(I_raw, S_raw);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Asserts reset mid-cycle and checks the outputs clear without a clock.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_N4", int'({I4, S4, Ip4, Sp4}), 0);
        check("async_reset_N1", int'({I1, S1, Ip1, Sp1}), 0);
        repeat (cycles) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Counts rising edges from "now" (just after a falling edge) until I
    // rises on each build, and records the strobe at that moment.
    task automatic measure_i_rise(input string tag);
        int lat4 = 0, lat1 = 0;
        int p4 = 0, p1 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            if (lat4 == 0 && I4 === 1'b1) begin lat4 = k; p4 = int'(Ip4); end
            if (lat1 == 0 && I1 === 1'b1) begin lat1 = k; p1 = int'(Ip1); end
        end
        check({tag, "_latency_N4"}, lat4, 6);
        check({tag, "_pulse_N4"},   p4,   1);
        check({tag, "_latency_N1"}, lat1, 3);
        check({tag, "_pulse_N1"},   p1,   1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        hold(3);

        // Clean rise on I.
        step(1'b1, 1'b0);
        measure_i_rise("clean_rise");
        hold(2);

        // Raise S, then drop and raise both together.
        step(1'b1, 1'b1);
        hold(8);
        step(1'b0, 1'b0);
        hold(8);
        step(1'b1, 1'b1);
        hold(8);

        // Bounce on I: 8 toggling cycles, then held high.
        step(1'b0, 1'b1);
        hold(8);
        for (int k = 0; k < 8; k++) step(k[0] ? 1'b0 : 1'b1, 1'b1);
        step(1'b1, 1'b1);
        hold(10);

        // Short glitch on S (3 cycles).
        step(1'b1, 1'b0);
        hold(8);
        step(1'b1, 1'b1);
        hold(2);
        step(1'b1, 1'b0);
        hold(8);

        // One-cycle glitch on I (accepted only by the N=1 build).
        step(1'b0, 1'b0);
        hold(8);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        hold(8);

        // Reset while both raw inputs are high and counts are in progress.
        step(1'b1, 1'b1);
        hold(2);
        do_reset(2);
        measure_i_rise("post_reset");
        hold(4);

        // Randomized segments with occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(39, 0) == 0) begin
                do_reset($urandom_range(2, 1));
            end else begin
                step(1'($urandom), 1'($urandom));
                hold($urandom_range(7, 0));
            end
        end

        hold(10);
        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
